// File: rtl/inst_fetch_port_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_port_if
// Bundles the fetch-side request/response signals and the byte-wide memory
// bus signals used by inst_fetch_port.
//   ram_inst_re    : fetch request enable (fetch stage -> port)
//   ram_inst_addr  : byte address of requested word (fetch stage -> port)
//   ram_inst       : assembled 32-bit instruction (port -> fetch stage)
//   ram_inst_busy  : fetch in progress (port -> fetch stage)
//   mem_req        : bus request (port -> arbiter)
//   mem_gnt        : bus grant (arbiter -> port)
//   mem_a          : byte address on the memory bus (port -> memory)
//   mem_din        : read data, one cycle after its address (memory -> port)
// slave  : the fetch port itself.
// master : the environment (fetch stage, arbiter and memory).
// -----------------------------------------------------------------------------
interface inst_fetch_port_if;
   logic        ram_inst_re;
   logic [31:0] ram_inst_addr;
   logic [31:0] ram_inst;
   logic        ram_inst_busy;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_a;
   logic [7:0]  mem_din;

   modport slave (
      input  ram_inst_re,
      input  ram_inst_addr,
      input  mem_gnt,
      input  mem_din,
      output ram_inst,
      output ram_inst_busy,
      output mem_req,
      output mem_a
   );

   modport master (
      output ram_inst_re,
      output ram_inst_addr,
      output mem_gnt,
      output mem_din,
      input  ram_inst,
      input  ram_inst_busy,
      input  mem_req,
      input  mem_a
   );
endinterface

// File: rtl/inst_fetch_port.sv
// -----------------------------------------------------------------------------
// inst_fetch_port
// Memory-side responder for instruction fetch. Accepts a word request, wins
// the shared byte-wide bus through the arbiter, issues four sequential byte
// reads and assembles them little-endian into a 32-bit instruction.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   rdy  : global ready; low freezes every register in the block
//   bus  : inst_fetch_port_if.slave (fetch request/response + memory bus)
// -----------------------------------------------------------------------------
module inst_fetch_port (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   inst_fetch_port_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RD   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  issue_cnt_q, issue_cnt_d;
   logic [1:0]  cap_cnt_q, cap_cnt_d;
   logic [23:0] shadow_q, shadow_d;
   logic [31:0] inst_q, inst_d;
   logic        busy_q, busy_d;
   logic        req_q, req_d;
   logic [31:0] mem_a_q, mem_a_d;

   logic abort;
   logic redirect;
   logic capture;
   logic done;

   // Request-side events while a fetch is outstanding. Redirect wins over
   // completion, so both are decoded ahead of the RD datapath.
   always_comb begin
      abort    = 1'b0;
      redirect = 1'b0;
      if (state_q != IDLE) begin
         abort    = !bus.ram_inst_re;
         redirect = bus.ram_inst_re && (bus.ram_inst_addr != addr_q);
      end
   end

   // The first RD cycle (issue counter still 1) has no data yet: mem_din
   // trails its address by one cycle.
   always_comb begin
      capture = (state_q == RD) && (issue_cnt_q != 3'd1);
      done    = capture && (cap_cnt_q == 2'd3);
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (bus.ram_inst_re) state_d = REQ;
            end
            REQ: begin
               if (abort)            state_d = IDLE;
               else if (redirect)    state_d = REQ;
               else if (bus.mem_gnt) state_d = RD;
            end
            RD: begin
               if (abort)         state_d = IDLE;
               else if (redirect) state_d = REQ;
               else if (done)     state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output / datapath logic
   always_comb begin
      addr_d      = addr_q;
      issue_cnt_d = issue_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      shadow_d    = shadow_q;
      inst_d      = inst_q;
      busy_d      = busy_q;
      req_d       = req_q;
      mem_a_d     = mem_a_q;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (bus.ram_inst_re) begin
                  addr_d = bus.ram_inst_addr;
                  busy_d = 1'b1;
                  req_d  = 1'b1;
               end
            end
            REQ, RD: begin
               if (abort) begin
                  busy_d = 1'b0;
                  req_d  = 1'b0;
               end else if (redirect) begin
                  // Restart from scratch so no byte of the old word survives.
                  addr_d      = bus.ram_inst_addr;
                  busy_d      = 1'b1;
                  req_d       = 1'b1;
                  issue_cnt_d = 3'd0;
                  cap_cnt_d   = 2'd0;
                  shadow_d    = 24'd0;
               end else if (state_q == REQ) begin
                  if (bus.mem_gnt) begin
                     mem_a_d     = addr_q;
                     issue_cnt_d = 3'd1;
                     cap_cnt_d   = 2'd0;
                  end
               end else begin
                  if (issue_cnt_q < 3'd4) begin
                     // Wraps naturally mod 2^32.
                     mem_a_d     = addr_q + {29'd0, issue_cnt_q};
                     issue_cnt_d = issue_cnt_q + 3'd1;
                  end
                  if (done) begin
                     inst_d = {bus.mem_din, shadow_q};
                     busy_d = 1'b0;
                     req_d  = 1'b0;
                  end else if (capture) begin
                     case (cap_cnt_q)
                        2'd0:    shadow_d[7:0]   = bus.mem_din;
                        2'd1:    shadow_d[15:8]  = bus.mem_din;
                        default: shadow_d[23:16] = bus.mem_din;
                     endcase
                     cap_cnt_d = cap_cnt_q + 2'd1;
                  end
               end
            end
            default: begin
               busy_d = 1'b0;
               req_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q      <= 32'd0;
         issue_cnt_q <= 3'd0;
         cap_cnt_q   <= 2'd0;
         shadow_q    <= 24'd0;
         inst_q      <= 32'd0;
         busy_q      <= 1'b0;
         req_q       <= 1'b0;
         mem_a_q     <= 32'd0;
      end else begin
         addr_q      <= addr_d;
         issue_cnt_q <= issue_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         shadow_q    <= shadow_d;
         inst_q      <= inst_d;
         busy_q      <= busy_d;
         req_q       <= req_d;
         mem_a_q     <= mem_a_d;
      end
   end

   assign bus.ram_inst      = inst_q;
   assign bus.ram_inst_busy = busy_q;
   assign bus.mem_req       = req_q;
   assign bus.mem_a         = mem_a_q;

endmodule

// File: doc/inst_fetch_port.md
# inst_fetch_port

Memory-side responder for the fetch stage's instruction request interface (`ram_inst_re` / `ram_inst_addr` -> `ram_inst` / `ram_inst_busy`). It accepts a word request, wins the shared byte-wide memory bus through the arbiter, issues four sequential byte reads, and assembles them little-endian into a 32-bit instruction. It sits between the fetch stage and the memory arbiter, alongside the data port.

## Interface
- none (no parameters)
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global ready; low freezes every register in the block.
- `ram_inst_re` in 1: fetch request enable from the fetch stage.
- `ram_inst_addr` in 32: byte address of the requested word.
- `ram_inst` out 32: assembled instruction; valid while `ram_inst_busy`=0 after a completed fetch.
- `ram_inst_busy` out 1: high from request acceptance until the word is delivered.
- `mem_req` out 1: bus request to the arbiter.
- `mem_gnt` in 1: bus grant; never revoked while `mem_req`=1.
- `mem_a` out 32: byte address driven onto the memory bus.
- `mem_din` in 8: read data; valid one cycle after its address.

## Operation
- Reset (`rst`=0, async): state IDLE, `ram_inst`=0, `ram_inst_busy`=0, `mem_req`=0, `mem_a`=0, counters 0, latched address 0.
- `rdy`=0: all state and outputs hold. The top level guarantees `mem_din` holds too.
- States: IDLE, REQ, RD.
- IDLE: if `ram_inst_re`=1, latch address A, set busy=1, mem_req=1, go to REQ.
- REQ: wait for `mem_gnt`=1. Then `mem_a`<=A, issue counter=1, capture counter=0, go to RD.
- RD issue: while the issue counter is below 4, `mem_a`<=A+issue counter, and the counter increments.
- RD capture: from the second RD cycle on, `mem_din` is written into byte lane [8k+7:8k] of a shadow word, where k is the capture counter; the counter then increments.
- RD completion: the edge that captures k=3 writes `ram_inst`<={din,b2,b1,b0}. It also clears busy and mem_req and returns to IDLE.
- Address arithmetic is mod 2^32; A=0xFFFFFFFE reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. No alignment check.
- Abort: `ram_inst_re`=0 in REQ or RD. On the next edge go to IDLE, busy=0, mem_req=0; `ram_inst` keeps its previous value.
- Redirect: `ram_inst_re`=1 with `ram_inst_addr`≠latched A in REQ or RD. Latch the new address, stay busy, return to REQ with mem_req=1, and discard partial bytes.
- Redirect has priority over completion on the same edge.
- `ram_inst` changes only on completion or reset. Back-to-back requests in IDLE start a new fetch the same edge `ram_inst_re` is seen.

## Timing
- Edge E0: IDLE samples a request; busy=1 after E0.
- Edge E1: grant seen in REQ; `mem_a`=A during [E1,E2).
- A+1, A+2 and A+3 follow on E2, E3 and E4.
- Bytes are captured at E3, E4, E5 and E6.
- At E6: `ram_inst` is valid and busy=0. Latency with immediate grant is 6 cycles from sampling to busy low.
- Each cycle of grant delay adds one cycle. Each `rdy`=0 cycle adds one cycle.
- `mem_a` is registered; `mem_req` is registered and never glitches.

## Test plan
- Basic fetch, immediate grant:
  - Stimulus: memory[0x100..0x103]=13 05 50 00, A=0x100.
  - Response: busy high 6 cycles, then `ram_inst`=0x00500513.
  - `mem_a` sequence: 0x100, 0x101, 0x102, 0x103.
- Grant delayed 3 cycles:
  - Response: busy high 9 cycles; `mem_req` held high throughout; same data as basic fetch.
- Redirect mid-RD: change the address to 0x200 after byte1 is issued.
  - `mem_a` restarts at 0x200.
  - `ram_inst` equals the word at 0x200, never a mix of bytes from both addresses.
- Abort: drop `ram_inst_re` during RD.
  - Response: busy=0 and mem_req=0 next cycle.
  - `ram_inst` keeps its prior value 0x00500513.
- Wrap plus `rdy` stall:
  - Stimulus: A=0xFFFFFFFE, with `rdy`=0 for 2 cycles during RD.
  - `mem_a` sequence: FFFFFFFE, FFFFFFFF, 00000000, 00000001.
  - Latency is 8 cycles.
- Async reset mid-RD:
  - Response: outputs clear to 0 immediately, without waiting for a `clk` edge.
  - After `rst` rises, the next request fetches correctly.
